// File: rtl/alu_pkg.sv
// alu_pkg: types shared by the alu execution block and its command-side driver.
//   opcode_t  - 3-bit ALU operation code
//   DATA_W    - operand / result width
//   alu_req_t - operation bundle issued to the ALU
package alu_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    OR  = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SLT = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;
endpackage

// File: rtl/alu_driver.sv
// alu_driver: valid/ready front end for the alu block, one operation in flight.
//   cmd_*      - command channel (valid/ready, opcode, operands, tag)
//   alu_*      - drive to / result from the alu (alu registers on negedge)
//   rsp_*      - response channel (valid/ready, result, zero flag, tag)
//   op_count   - completed responses, wraps modulo 2^CNT_W
//   clk, reset - single clock, asynchronous active-high reset
module alu_driver
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  opcode_t           cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output opcode_t           alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  alu_req_t         issue_q;
  logic [TAG_W-1:0] tag_q;

  // Decode of the state register only; never looks at cmd_valid/rsp_ready.
  assign cmd_ready  = (state == IDLE);
  assign alu_opcode = issue_q.op;
  assign alu_a      = issue_q.a;
  assign alu_b      = issue_q.b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      issue_q   <= '{op: ADD, a: '0, b: '0};
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_tag   <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          issue_q <= '{op: cmd_opcode, a: cmd_a, b: cmd_b};
          tag_q   <= cmd_tag;
          state   <= EXEC;
        end
        // The alu updated on the negedge inside this cycle, so its result
        // is settled by this posedge.
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_tag   <= tag_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  opcode_t    cmd_opcode = ADD;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_tag = '0;
  opcode_t    alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out = '0;
  logic       alu_zero = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic [3:0] rsp_tag;
  logic [15:0] op_count;

  // Narrow-counter copy fed the same stimulus, to exercise counter wrap.
  logic       cmd_ready2, rsp_valid2, rsp_zero2;
  opcode_t    alu_opcode2;
  logic [7:0] alu_a2, alu_b2, rsp_data2;
  logic [3:0] rsp_tag2;
  logic [3:0] op_count2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_driver #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .op_count(op_count));

  alu_driver #(.TAG_W(4), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .rsp_zero(rsp_zero2), .rsp_tag(rsp_tag2), .op_count(op_count2));

  function automatic logic [7:0] alu_ref(opcode_t op, logic [7:0] a, logic [7:0] b);
    int sa, sb;
    sa = (a >= 128) ? int'(a) - 256 : int'(a);
    sb = (b >= 128) ? int'(b) - 256 : int'(b);
    case (op)
      ADD: return 8'((int'(a) + int'(b)) % 256);
      SUB: return 8'((int'(a) - int'(b) + 256) % 256);
      OR:  return a | b;
      AND: return a & b;
      XOR: return a ^ b;
      SLL: return (b >= 8) ? 8'h00 : 8'((int'(a) * (1 << b)) % 256);
      SRL: return (b >= 8) ? 8'h00 : 8'(int'(a) / (1 << b));
      default: return (sa < sb) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // Behavioural ALU: registers its result on the negedge.
  always @(negedge clk) begin
    alu_out  <= alu_ref(alu_opcode, alu_a, alu_b);
    alu_zero <= (alu_ref(alu_opcode, alu_a, alu_b) == 8'h00);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(string nm);
    chk({nm, " op_count"}, 32'(op_count), 32'(exp_cnt % 65536));
    chk({nm, " op_count4"}, 32'(op_count2), 32'(exp_cnt % 16));
  endtask

  task automatic wait_ready(string nm);
    int n = 0;
    while (!cmd_ready && n < 10) begin step(); n++; end
    if (!cmd_ready) chk({nm, " ready timeout"}, 0, 1);
  endtask

  task automatic do_op(string nm, opcode_t op, logic [7:0] a, logic [7:0] b,
                       logic [3:0] tag, int dly, logic [7:0] ed, logic ez);
    wait_ready(nm);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk({nm, " exec ready"}, 32'(cmd_ready), 0);
    chk({nm, " exec rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, " alu_ab"}, {alu_opcode, alu_a, alu_b}, {op, a, b});
    step();
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 1);
    chk({nm, " rsp"}, {rsp_tag, rsp_zero, rsp_data}, {tag, ez, ed});
    for (int i = 0; i < dly; i++) begin
      step();
      chk({nm, " hold"}, {cmd_ready, rsp_valid, rsp_tag, rsp_zero, rsp_data},
          {1'b0, 1'b1, tag, ez, ed});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt++;
    chk({nm, " post rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, " post ready"}, 32'(cmd_ready), 1);
    chk_cnt(nm);
  endtask

  typedef struct {
    opcode_t    op;
    logic [7:0] a, b;
    logic [3:0] tag;
    int         dly;
    logic [7:0] ed;
    logic       ez;
  } vec_t;

  vec_t vecs[9];
  logic [3:0] tagq[$];
  logic [7:0] datq[$];

  initial begin
    vecs[0] = '{ADD, 8'h05, 8'h03, 4'h1, 0, 8'h08, 1'b0};
    vecs[1] = '{SUB, 8'h2A, 8'h2A, 4'h7, 0, 8'h00, 1'b1};
    vecs[2] = '{ADD, 8'hFF, 8'h01, 4'h2, 5, 8'h00, 1'b1};
    vecs[3] = '{SUB, 8'h03, 8'h05, 4'h3, 1, 8'hFE, 1'b0};
    vecs[4] = '{OR,  8'hA0, 8'h0B, 4'h4, 0, 8'hAB, 1'b0};
    vecs[5] = '{AND, 8'hF0, 8'h0F, 4'h5, 2, 8'h00, 1'b1};
    vecs[6] = '{XOR, 8'hFF, 8'h5A, 4'h6, 0, 8'hA5, 1'b0};
    vecs[7] = '{SLL, 8'h01, 8'h03, 4'h8, 0, 8'h08, 1'b0};
    vecs[8] = '{SLT, 8'h80, 8'h01, 4'h9, 0, 8'h01, 1'b0};

    // Reset values
    #12;
    chk("reset ready", 32'(cmd_ready), 1);
    chk("reset alu", {alu_opcode, alu_a, alu_b}, {ADD, 8'h00, 8'h00});
    chk("reset rsp", {rsp_valid, rsp_zero, rsp_tag, rsp_data}, 0);
    chk_cnt("reset");
    step();
    reset = 1'b0;
    step();
    chk("release ready", 32'(cmd_ready), 1);
    chk("release rsp_valid", 32'(rsp_valid), 0);

    // Reset during EXEC abandons the operation
    cmd_opcode = ADD; cmd_a = 8'h10; cmd_b = 8'h20; cmd_tag = 4'hC; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rstexec in exec", 32'(cmd_ready), 0);
    reset = 1'b1;
    #1;
    chk("rstexec async", {rsp_valid, alu_a}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstexec no rsp", 32'(rsp_valid), 0);
    end
    chk_cnt("rstexec");
    rsp_ready = 1'b0;

    // Table-driven directed vectors
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].tag, vecs[i].dly, vecs[i].ed, vecs[i].ez);

    // Command pending during RESP is held off until IDLE
    wait_ready("pend");
    cmd_opcode = ADD; cmd_a = 8'hFF; cmd_b = 8'h01; cmd_tag = 4'h3; cmd_valid = 1'b1;
    step();
    cmd_opcode = OR; cmd_a = 8'h11; cmd_b = 8'h22; cmd_tag = 4'h4;
    step();
    chk("pend rsp", {rsp_valid, rsp_tag, rsp_zero, rsp_data}, {1'b1, 4'h3, 1'b1, 8'h00});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pend hold", {cmd_ready, rsp_valid, rsp_zero, rsp_data, alu_a},
          {1'b0, 1'b1, 1'b1, 8'h00, 8'hFF});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("pend idle", {cmd_ready, rsp_valid, alu_a}, {1'b1, 1'b0, 8'hFF});
    chk_cnt("pend");
    step();
    cmd_valid = 1'b0;
    chk("pend accepted", {cmd_ready, alu_opcode, alu_a, alu_b}, {1'b0, OR, 8'h11, 8'h22});
    step();
    chk("pend rsp2", {rsp_valid, rsp_tag, rsp_zero, rsp_data}, {1'b1, 4'h4, 1'b0, 8'h33});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt++;
    chk_cnt("pend2");

    // Back-to-back with cmd_valid and rsp_ready held high
    begin
      int k = 0, got = 0, last = -1;
      cmd_opcode = XOR; cmd_a = 8'h00; cmd_b = 8'h3C; cmd_tag = 4'hA;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        logic acc, hs;
        acc = cmd_valid && cmd_ready;
        hs  = rsp_valid && rsp_ready;
        step();
        if (hs) exp_cnt++;
        if (acc) begin
          tagq.push_back(cmd_tag);
          datq.push_back(alu_ref(cmd_opcode, cmd_a, cmd_b));
          if (last >= 0) chk("b2b interval", 32'(cyc - last), 3);
          last = cyc;
          k++;
          if (k < 4) begin cmd_a = 8'(k); cmd_tag = 4'(4'hA + k); end
          else cmd_valid = 1'b0;
        end
        if (rsp_valid) begin
          chk("b2b rsp", {rsp_tag, rsp_data}, {tagq.pop_front(), datq.pop_front()});
          got++;
        end
        chk_cnt("b2b");
      end
      if (got < 4) chk("b2b timeout", 32'(got), 4);
      cmd_valid = 1'b0;
      step();
      exp_cnt++;
      rsp_ready = 1'b0;
      chk_cnt("b2b end");
    end

    // Randomized operations against the reference
    for (int i = 0; i < 30; i++) begin
      opcode_t op;
      logic [7:0] a, b, r;
      op = opcode_t'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = (op == SLL || op == SRL) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if (i % 5 == 0) b = (op == SUB || op == XOR) ? a : b;
      r  = alu_ref(op, a, b);
      do_op($sformatf("rnd%0d", i), op, a, b, 4'($urandom), $urandom_range(0, 2),
            r, (r == 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side front end for the `alu` execution block. It accepts operation requests over a valid/ready command channel and drives `opcode`, `a` and `b` into the ALU. It then captures the ALU's `out` and `zero` once the ALU's negedge update has settled, and returns them with the request tag over a valid/ready response channel. One operation is in flight at a time; a wrapping counter records the number of completed operations.

## Interface
- `TAG_W`, 4: width of the request tag echoed with each response.
- `CNT_W`, 16: width of the completed-operation counter.
- `clk`  in  1  single clock; all driver state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver can accept a command.
- `cmd_opcode`  in  `opcode_t` (3)  operation requested.
- `cmd_a`  in  8  operand A.
- `cmd_b`  in  8  operand B; shift amount for SLL/SRL.
- `cmd_tag`  in  `TAG_W`  caller tag.
- `alu_opcode`  out  `opcode_t`  to ALU `opcode`.
- `alu_a`  out  8  to ALU `a`.
- `alu_b`  out  8  to ALU `b`.
- `alu_out`  in  8  from ALU `out`.
- `alu_zero`  in  1  from ALU `zero`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  8  captured ALU result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_tag`  out  `TAG_W`  tag of the originating command.
- `op_count`  out  `CNT_W`  completed responses, modulo 2^`CNT_W`.

## Operation
- FSM states:
  - IDLE:
    - `cmd_ready`=1.
    - On `cmd_valid && cmd_ready`, register opcode/a/b into `alu_*` and the tag into an internal register, then go to EXEC.
  - EXEC: lasts exactly one cycle, with `cmd_ready`=0. At the next posedge:
    - capture `alu_out` into `rsp_data`, `alu_zero` into `rsp_zero`, and the internal tag into `rsp_tag`;
    - set `rsp_valid`=1;
    - go to RESP.
  - RESP:
    - `rsp_valid` stays 1 with data and tag stable until `rsp_ready`=1.
    - On the handshake posedge: clear `rsp_valid`, increment `op_count`, return to IDLE.
- `alu_*` outputs hold their last issued values in RESP and IDLE. They change only on command acceptance.
- Operands pass through unmodified. The driver performs no arithmetic on data; the result is whatever the ALU produced.
- `cmd_ready` is a registered state decode and has no combinational dependence on `cmd_valid` or `rsp_ready`.
- A command presented during EXEC or RESP is not accepted. The caller holds it, and it is accepted in the first IDLE cycle.
- `op_count` wraps from all-ones to 0 with no flag.
- Reset values, asserted asynchronously:
  - state IDLE, `cmd_ready`=1 once reset is released;
  - `alu_opcode`=ADD, `alu_a`=0, `alu_b`=0;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_tag`=0, `op_count`=0.
- Reset mid-operation (EXEC or RESP) abandons the operation. No response is produced and `op_count` is not incremented.

## Timing
- Command accepted at posedge N: `alu_*` are valid after N, and the ALU registers its result at the negedge between N and N+1.
- At posedge N+1, `alu_out`/`alu_zero` are sampled and `rsp_valid` rises.
- Minimum latency from acceptance to response is 1 cycle.
- Minimum issue interval is 3 cycles: accept → EXEC → RESP with `rsp_ready` already 1 → IDLE → next accept.
- `rsp_*` are stable whenever `rsp_valid`=1 and `rsp_ready`=0.
- `op_count` updates on the same posedge as the response handshake.

## Structure
- Shared package `alu_pkg`:
  - `opcode_t` enum, values ADD=0, SUB=1, OR=2, AND=3, XOR=4, SLL=5, SRL=6, SLT=7;
  - data width constant 8.
- Both `alu` and `alu_driver` import `opcode_t` from `alu_pkg`.
- No sub-module. The FSM, capture registers and counter are inline.
- Top-level bench wrapper `alu_subsys` instantiates `alu_driver` and `alu` back to back.

## Test plan
- Reset release: all outputs at their reset values, `cmd_ready`=1 in the first cycle after reset is released.
- ADD, a=8'h05, b=8'h03, tag=4'h1, `rsp_ready`=1 → `rsp_valid` one cycle after acceptance, `rsp_data`=8'h08, `rsp_zero`=0, `rsp_tag`=4'h1, `op_count`=1.
- SUB, a=8'h2A, b=8'h2A, tag=4'h7 → `rsp_data`=8'h00, `rsp_zero`=1, `rsp_tag`=4'h7.
- ADD 8'hFF+8'h01 with `rsp_ready` held 0 for 5 cycles → response stays 8'h00/zero=1 and stable, `cmd_ready`=0 throughout, a second pending command is accepted only after the handshake.
- Back-to-back commands with `cmd_valid` held high → each acceptance 3 cycles apart, tags returned in order, `op_count` increments once per handshake.
- Assert `reset` in EXEC → no response, `op_count` unchanged at 0. Separately, preload `op_count` to all-ones via 2^16−1 operations (or force) and complete one more → `op_count`=0.
